ldl_sfifo_rd_stream: RTL

- Read-side adapter placed directly downstream of the synchronous FIFO.
- Drains the FIFO through its empty/re/dout interface and presents the data as a valid/ready stream, using a 2-entry output register plus skid buffer.
- Supports both FIFO read modes: show-ahead (AHEAD=1) and registered read (AHEAD=0).
- Sustains one beat per cycle under continuous ready, with no bubbles and no data loss under backpressure.

---
 rtl/ldl_sfifo_rd_stream.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ldl_sfifo_rd_stream.sv
// Read-side FIFO-to-stream adapter: drains empty/re/dout into valid/ready via an output
// register plus skid entry. Optional synchronous flush port under LDL_SFIFO_RD_STREAM_FLUSH_EN.
module ldl_sfifo_rd_stream #(
  parameter int unsigned DW    = 8,
  parameter bit          AHEAD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_re,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
`ifdef LDL_SFIFO_RD_STREAM_FLUSH_EN
  input  logic          flush,
`endif
  output logic [1:0]    occ
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          valid_q, valid_d;
  logic          inflight_q;
  logic          pop;
  logic          arrival;
  logic          flush_int;
  logic [2:0]    credit;

`ifdef LDL_SFIFO_RD_STREAM_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  assign pop = valid_q & m_ready;

  // Entries held plus words already requested, net of the beat leaving this cycle.
  assign credit = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Gated by reset so no read is issued while the FIFO itself is being cleared.
  assign fifo_re = rst & ~fifo_empty & ~flush_int & (credit < 3'd2);

  assign arrival = AHEAD ? fifo_re : inflight_q;

  if (AHEAD) begin : g_show_ahead
    assign inflight_q = 1'b0;
  end else begin : g_registered
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= fifo_re;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (arrival) begin
          state_d = StOne;
          out_d   = fifo_dout;
        end
      end
      StOne: begin
        if (pop && arrival) begin
          out_d = fifo_dout;
        end else if (pop) begin
          state_d = StEmpty;
        end else if (arrival) begin
          state_d = StTwo;
          skid_d  = fifo_dout;
        end
      end
      StTwo: begin
        if (pop) begin
          out_d = skid_q;
          if (arrival) begin
            skid_d = fifo_dout;
          end else begin
            state_d = StOne;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops everything, including a word landing this edge; m_data keeps its value.
    if (flush_int) begin
      state_d = StEmpty;
      out_d   = out_q;
      skid_d  = skid_q;
    end
    valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = out_q;
  assign occ     = state_q;

`ifndef SYNTHESIS
  // The credit rule must never let a word arrive while both entries are held.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(state_q == StTwo && !pop && arrival))
        else $error("ldl_sfifo_rd_stream: arrival while full");
    end
  end
`endif

endmodule
